// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache-to-memory miss arbiter: FSM states, port ids,
// default widths and the round-robin pick used by the arbiter.
package cache_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_LINE_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_id_t;

    // On a tie the port that was not served last wins; a lone request wins outright.
    function automatic port_id_t rr_pick(input logic i_req, input logic d_req,
                                         input port_id_t last_grant);
        port_id_t pick;
        if (i_req && d_req) begin
            if (last_grant == PORT_I) pick = PORT_D;
            else                      pick = PORT_I;
        end else if (d_req) begin
            pick = PORT_D;
        end else begin
            pick = PORT_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side miss signals.
// slave = the arbiter, master = caches plus memory around it.
interface cache_mem_arbiter_if #(
    parameter int ADDR_WIDTH = cache_arb_pkg::DEF_ADDR_WIDTH,
    parameter int LINE_WIDTH = cache_arb_pkg::DEF_LINE_WIDTH
) ();

    logic                  i_read;
    logic                  i_write;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [LINE_WIDTH-1:0] i_wdata;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  i_read, i_write, i_address, i_wdata,
        output i_rdata, i_resp,
        input  d_read, d_write, d_address, d_wdata,
        output d_rdata, d_resp,
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output i_read, i_write, i_address, i_wdata,
        input  i_rdata, i_resp,
        output d_read, d_write, d_address, d_wdata,
        input  d_rdata, d_resp,
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );

endinterface

// File: rtl/cache_mem_arbiter.sv
// Serialises I-cache and D-cache line fills/writebacks onto one memory port
// with round-robin fairness; responses go only to the granted cache.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    cache_mem_arbiter_if.slave  bus
);

    arb_state_t state, state_next;
    port_id_t   last_grant, last_grant_next;

    logic                  i_req, d_req;
    logic                  sel_read, sel_write;
    logic [ADDR_WIDTH-1:0] sel_address;
    logic [LINE_WIDTH-1:0] sel_wdata;

    assign i_req = bus.i_read | bus.i_write;
    assign d_req = bus.d_read | bus.d_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= PORT_I;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    // Every grant passes back through IDLE, so a request still held high in
    // the resp cycle is never mistaken for a new one.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    if (rr_pick(i_req, d_req, last_grant) == PORT_D) state_next = SERVE_D;
                    else                                             state_next = SERVE_I;
                end
            end
            SERVE_I: begin
                if (bus.mem_resp) begin
                    state_next      = IDLE;
                    last_grant_next = PORT_I;
                end else if (!i_req) begin
                    state_next = IDLE;
                end
            end
            SERVE_D: begin
                if (bus.mem_resp) begin
                    state_next      = IDLE;
                    last_grant_next = PORT_D;
                end else if (!d_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Port mux: D is the default path, I only while serving I.
    always_comb begin
        if (state == SERVE_I) begin
            sel_read    = bus.i_read;
            sel_write   = bus.i_write;
            sel_address = bus.i_address;
            sel_wdata   = bus.i_wdata;
        end else begin
            sel_read    = bus.d_read;
            sel_write   = bus.d_write;
            sel_address = bus.d_address;
            sel_wdata   = bus.d_wdata;
        end
    end

    always_comb begin
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = sel_address;
        bus.mem_wdata   = sel_wdata;
        bus.i_resp      = 1'b0;
        bus.d_resp      = 1'b0;
        if (state == SERVE_I || state == SERVE_D) begin
            // a simultaneous read+write is treated as a writeback
            bus.mem_write = sel_write;
            bus.mem_read  = sel_read & ~sel_write;
        end
        if (state == SERVE_I) bus.i_resp = bus.mem_resp;
        if (state == SERVE_D) bus.d_resp = bus.mem_resp;
    end

    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: expected memory transactions are
// queued as cache requests are raised and checked as they appear on the mem port.
module tb_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam int K_RAISE  = 0;  // grant one cycle after the request was raised
    localparam int K_BUBBLE = 1;  // grant two cycles after the previous resp

    typedef struct {
        bit          port;   // 0 = I, 1 = D
        bit          rd;
        bit          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
        int          kind;
        int          raise_cyc;
    } exp_t;

    logic clk, rst;
    int   cyc = 0;
    int   n_checks = 0, n_errors = 0;
    exp_t sb[$];
    exp_t cur;
    bit   busy = 0;
    int   last_resp_cyc = 0;
    bit   lg_model = 0;
    bit   mem_auto = 1;
    int   mem_lat  = 3;
    int   mcnt     = 0;
    logic [LW-1:0] wd_a = {8{32'h1234_5678}};
    logic [LW-1:0] wd_b = {8{32'hDEAD_BEEF}};

    cache_mem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        if (a == 32'h1000) return {32{8'hA5}};
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit p, input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [LW-1:0] wd, input int kind);
        exp_t e;
        e.port = p; e.rd = rd; e.wr = wr; e.addr = a; e.wdata = wd;
        e.rdata = line_of(a); e.kind = kind; e.raise_cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic drive(input bit p, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [LW-1:0] wd);
        if (p) begin
            bus.d_read = rd; bus.d_write = wr; bus.d_address = a; bus.d_wdata = wd;
        end else begin
            bus.i_read = rd; bus.i_write = wr; bus.i_address = a; bus.i_wdata = wd;
        end
    endtask

    // Initiator: raise, hold until resp, drop one cycle later.
    task automatic cache_req(input bit p, input bit rd, input bit wr, input logic [AW-1:0] a,
                             input logic [LW-1:0] wd);
        bit got = 0;
        drive(p, rd, wr, a, wd);
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = p ? bus.d_resp : bus.i_resp;
        end
        if (!got) check(p ? "d_req_timeout" : "i_req_timeout", 0, 1);
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, a, wd);
    endtask

    task automatic wait_mem_active(input string tag);
        for (int n = 0; n < 10 && !(bus.mem_read || bus.mem_write); n++) @(negedge clk);
        check(tag, bus.mem_read | bus.mem_write, 1);
    endtask

    task automatic tie(input logic [AW-1:0] ia, input logic [AW-1:0] da);
        if (lg_model == 1'b0) begin
            push(1'b1, 1'b1, 1'b0, da, '0, K_RAISE);
            push(1'b0, 1'b1, 1'b0, ia, '0, K_BUBBLE);
        end else begin
            push(1'b0, 1'b1, 1'b0, ia, '0, K_RAISE);
            push(1'b1, 1'b1, 1'b0, da, '0, K_BUBBLE);
        end
        fork
            cache_req(1'b0, 1'b1, 1'b0, ia, '0);
            cache_req(1'b1, 1'b1, 1'b0, da, '0);
        join
    endtask

    // Memory model: answers an active request after mem_lat cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1 bus.mem_resp = 1'b0;
            #1;
            if (mem_auto && (bus.mem_read || bus.mem_write)) begin
                mcnt++;
                if (mcnt >= mem_lat) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = line_of(bus.mem_address);
                    mcnt = 0;
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each new mem transaction, checks resp routing.
    always @(negedge clk) begin
        if (bus.mem_read || bus.mem_write) begin
            if (busy) begin
                check("addr_stable", bus.mem_address, cur.addr);
            end else if (sb.size() == 0) begin
                check("unexpected_txn", bus.mem_address, '1);
            end else begin
                cur  = sb.pop_front();
                busy = 1;
                check("txn_addr", bus.mem_address, cur.addr);
                check("txn_write", bus.mem_write, cur.wr);
                check("txn_read", bus.mem_read, cur.rd & ~cur.wr);
                if (cur.wr) check("txn_wdata", bus.mem_wdata, cur.wdata);
                if (cur.kind == K_RAISE) check("grant_latency", cyc - cur.raise_cyc, 1);
                else                     check("idle_bubble", cyc - last_resp_cyc, 2);
            end
        end
        if (bus.i_resp || bus.d_resp) begin
            if (!busy) begin
                check("resp_without_txn", {bus.i_resp, bus.d_resp}, 2'b00);
            end else begin
                check("resp_port", {bus.i_resp, bus.d_resp}, cur.port ? 2'b01 : 2'b10);
                if (cur.rd && !cur.wr)
                    check("resp_rdata", cur.port ? bus.d_rdata : bus.i_rdata, cur.rdata);
                busy = 0;
                last_resp_cyc = cyc;
                lg_model = cur.port;
            end
        end else if (busy && !(bus.mem_read || bus.mem_write)) begin
            busy = 0;  // aborted or reset transfer
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        drive(1'b0, 1'b1, 1'b0, 32'h2000, '0);
        drive(1'b1, 1'b1, 1'b0, 32'h3000, '0);
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_read", bus.mem_read, 0);
        check("rst_mem_write", bus.mem_write, 0);
        check("rst_i_resp", bus.i_resp, 0);
        check("rst_d_resp", bus.d_resp, 0);
        @(posedge clk); #1;
        rst = 0;
        lg_model = 1'b0;

        // four ties, the first straight out of reset
        for (int t = 0; t < 4; t++) tie(32'h2000 + t * 32'h100, 32'h3000 + t * 32'h100);

        // lone D fill
        mem_lat = 5;
        push(1'b1, 1'b1, 1'b0, 32'h1000, '0, K_RAISE);
        cache_req(1'b1, 1'b1, 1'b0, 32'h1000, '0);

        // D writeback then fill, back to back
        mem_lat = 3;
        push(1'b1, 1'b0, 1'b1, 32'h4000, wd_a, K_RAISE);
        cache_req(1'b1, 1'b0, 1'b1, 32'h4000, wd_a);
        push(1'b1, 1'b1, 1'b0, 32'h5000, '0, K_RAISE);
        cache_req(1'b1, 1'b1, 1'b0, 32'h5000, '0);

        // I raised while D is in flight
        mem_lat = 5;
        push(1'b1, 1'b1, 1'b0, 32'h8000, '0, K_RAISE);
        push(1'b0, 1'b1, 1'b0, 32'h9000, '0, K_BUBBLE);
        fork
            cache_req(1'b1, 1'b1, 1'b0, 32'h8000, '0);
            begin
                repeat (2) @(posedge clk);
                #1;
                cache_req(1'b0, 1'b1, 1'b0, 32'h9000, '0);
            end
        join

        // reset while serving I
        mem_auto = 0;
        push(1'b0, 1'b1, 1'b0, 32'h6000, '0, K_RAISE);
        drive(1'b0, 1'b1, 1'b0, 32'h6000, '0);
        wait_mem_active("rst_test_start");
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        lg_model = 1'b0;
        mem_auto = 1;
        push(1'b0, 1'b1, 1'b0, 32'h6000, '0, K_RAISE);
        @(negedge clk);
        check("rst_clears_read", bus.mem_read, 0);
        check("rst_no_i_resp", bus.i_resp, 0);
        cache_req(1'b0, 1'b1, 1'b0, 32'h6000, '0);

        // spurious mem_resp while idle, then a dual read+write request
        mem_auto = 0;
        @(posedge clk); #3;
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = '1;
        @(negedge clk);
        check("spur_i_resp", bus.i_resp, 0);
        check("spur_d_resp", bus.d_resp, 0);
        check("rdata_bcast_i", bus.i_rdata, '1);
        check("rdata_bcast_d", bus.d_rdata, '1);
        @(posedge clk); #1;
        mem_auto = 1;
        push(1'b1, 1'b1, 1'b1, 32'hA000, wd_b, K_RAISE);
        cache_req(1'b1, 1'b1, 1'b1, 32'hA000, wd_b);

        // I drops its request mid-transfer; last_grant must stay D
        mem_auto = 0;
        push(1'b0, 1'b1, 1'b0, 32'hB000, '0, K_RAISE);
        drive(1'b0, 1'b1, 1'b0, 32'hB000, '0);
        wait_mem_active("abort_start");
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'hB000, '0);
        @(negedge clk);
        check("abort_drops_read", bus.mem_read, 0);
        check("abort_no_resp", bus.i_resp, 0);
        @(posedge clk); #1;
        mem_auto = 1;
        tie(32'hC000, 32'hD000);

        for (int n = 0; n < 50 && (sb.size() != 0 || busy); n++) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
